// File: rtl/pattern_tx_pkg.sv
// ---------------------------------------------------------------------------
// pattern_tx_pkg
// Shared types and defaults for the serial pattern transmitter.
//   tx_state_e     : transmitter FSM state encoding (IDLE, SHIFT, GAP)
//   PAT_W_DEFAULT  : default pattern width
//   PAT_DEFAULT    : default pattern, sent when use_default is set at start
//   CNT_W_DEFAULT  : default repetition counter width
//   GAP_W_DEFAULT  : default gap-length field width
// ---------------------------------------------------------------------------
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  localparam int         PAT_W_DEFAULT = 4;
  localparam logic [3:0] PAT_DEFAULT   = 4'b1001;
  localparam int         CNT_W_DEFAULT = 8;
  localparam int         GAP_W_DEFAULT = 4;

endpackage

// File: rtl/tx_down_counter.sv
// ---------------------------------------------------------------------------
// tx_down_counter
// Loadable down-counter with zero flag. Load has priority over decrement;
// a decrement request at zero holds the value instead of wrapping.
// Ports:
//   clk_i       : rising-edge clock
//   reset_i     : synchronous active-high reset, clears the count
//   load_i      : load load_val_i on the next edge
//   load_val_i  : value to load
//   dec_i       : decrement by one on the next edge
//   count_o     : current count
//   zero_o      : count is zero
// ---------------------------------------------------------------------------
module tx_down_counter
  import pattern_tx_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/pattern_serial_tx.sv
// ---------------------------------------------------------------------------
// pattern_serial_tx
// Serializes a PAT_W-bit pattern MSB-first, repeated rep_count times with
// gap_len zero bits between repetitions (no trailing gap). All outputs are
// registered; done pulses for one cycle in the IDLE cycle that follows the
// final bit of a completed transfer. abort or reset end a transfer with no
// done pulse.
//
// Optional build macro PATTERN_TX_CONTINUOUS_EN: when defined, a start with
// rep_count==0 repeats the pattern (and gaps) endlessly until abort/reset.
// Without it, such a start is ignored.
//
// Ports:
//   clk_i          : rising-edge clock
//   reset_i        : synchronous active-high reset
//   start_i        : transfer request, sampled only while idle
//   use_default_i  : at start, 1 selects DEF_PATTERN, 0 selects pattern_in_i
//   pattern_in_i   : pattern, latched on accepted start
//   rep_count_i    : repetitions, latched on accepted start
//   gap_len_i      : zero bits between repetitions, latched on accepted start
//   abort_i        : terminate current transfer
//   dout_o         : serial data
//   dout_valid_o   : dout_o carries a transmitted bit (pattern or gap)
//   busy_o         : transfer in progress
//   done_o         : one-cycle completion pulse
// ---------------------------------------------------------------------------
module pattern_serial_tx
  import pattern_tx_pkg::*;
#(
  parameter int               PAT_W       = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(PAT_DEFAULT),
  parameter int               CNT_W       = CNT_W_DEFAULT,
  parameter int               GAP_W       = GAP_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             use_default_i,
  input  logic [PAT_W-1:0] pattern_in_i,
  input  logic [CNT_W-1:0] rep_count_i,
  input  logic [GAP_W-1:0] gap_len_i,
  input  logic             abort_i,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BIT_W = $clog2(PAT_W);

  tx_state_e        state_q;
  logic [PAT_W-1:0] pat_q;
  logic [GAP_W-1:0] gap_len_q;
  logic             dout_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [BIT_W-1:0] bit_cnt;
  logic             bit_zero;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_zero_unused;
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_zero;

  logic             start_ok;
  logic             accept;
  logic             kill;
  logic             rep_last;
  logic             gap_last;
  logic             gap_en;
  logic             shift_wrap;
  logic             bit_load;
  logic             bit_dec;
  logic             gap_load;
  logic             gap_dec;
  logic             rep_dec;
  logic [BIT_W-1:0] bit_idx_nxt;
  logic [PAT_W-1:0] pat_sel;

`ifdef PATTERN_TX_CONTINUOUS_EN
  // rep_count==0 is a legal start: the rep counter then sits at zero, so
  // rep_last never fires and the transfer runs until abort/reset.
  assign start_ok = 1'b1;
`else
  assign start_ok = (rep_count_i != '0);
`endif

  assign pat_sel = use_default_i ? DEF_PATTERN : pattern_in_i;

  always_comb begin
    accept      = (state_q == ST_IDLE) && start_i && start_ok;
    kill        = (state_q != ST_IDLE) && abort_i;
    rep_last    = (rep_cnt == CNT_W'(1));
    gap_last    = (gap_cnt == GAP_W'(1));
    gap_en      = (gap_len_q != '0);
    // Last bit of a repetition is on the line and another repetition follows.
    shift_wrap  = (state_q == ST_SHIFT) && !kill && bit_zero && !rep_last;
    bit_load    = accept
                  || (shift_wrap && !gap_en)
                  || ((state_q == ST_GAP) && !kill && gap_last);
    bit_dec     = (state_q == ST_SHIFT) && !kill && !bit_zero;
    gap_load    = shift_wrap && gap_en;
    gap_dec     = (state_q == ST_GAP) && !kill && !gap_last;
    // Zero rep count means endless mode; never decrement it.
    rep_dec     = shift_wrap && !rep_zero;
    bit_idx_nxt = bit_cnt - 1'b1;
  end

  // Bit index: position of the bit currently on dout.
  tx_down_counter #(.W(BIT_W)) u_bit_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (bit_load),
    .load_val_i (BIT_W'(PAT_W - 1)),
    .dec_i      (bit_dec),
    .count_o    (bit_cnt),
    .zero_o     (bit_zero)
  );

  // Gap counter: gap cycles remaining, including the one on the line.
  tx_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (gap_load),
    .load_val_i (gap_len_q),
    .dec_i      (gap_dec),
    .count_o    (gap_cnt),
    .zero_o     (gap_zero_unused)
  );

  // Rep counter: repetitions remaining, including the one being sent.
  tx_down_counter #(.W(CNT_W)) u_rep_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (accept),
    .load_val_i (rep_count_i),
    .dec_i      (rep_dec),
    .count_o    (rep_cnt),
    .zero_o     (rep_zero)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      gap_len_q <= '0;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            pat_q     <= pat_sel;
            gap_len_q <= gap_len_i;
            dout_q    <= pat_sel[PAT_W-1];
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end else begin
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (kill) begin
            state_q <= ST_IDLE;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (!bit_zero) begin
            dout_q <= pat_q[bit_idx_nxt];
          end else if (rep_last) begin
            state_q <= ST_IDLE;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_en) begin
            state_q <= ST_GAP;
            dout_q  <= 1'b0;
          end else begin
            dout_q <= pat_q[PAT_W-1];
          end
        end
        ST_GAP: begin
          if (kill) begin
            state_q <= ST_IDLE;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (gap_last) begin
            state_q <= ST_SHIFT;
            dout_q  <= pat_q[PAT_W-1];
          end
        end
        default: begin
          state_q <= ST_IDLE;
          dout_q  <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_pattern_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_pattern_serial_tx
// Scoreboard bench: each launched transfer pushes its expected output items
// (bit value + absolute cycle, or the done pulse) into a queue; a monitor
// pops and compares every cycle the DUT shows dout_valid or done.
// ---------------------------------------------------------------------------
module tb_pattern_serial_tx;

  localparam logic [3:0] DEF_PAT = 4'b1001;

  logic       clk;
  logic       reset;
  logic       start;
  logic       use_default;
  logic [3:0] pattern_in;
  logic [7:0] rep_count;
  logic [3:0] gap_len;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  typedef struct {
    bit is_done;
    bit b;
    int cyc;
  } item_t;

  item_t exp_q[$];

  pattern_serial_tx dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .use_default_i (use_default),
    .pattern_in_i  (pattern_in),
    .rep_count_i   (rep_count),
    .gap_len_i     (gap_len),
    .abort_i       (abort),
    .dout_o        (dout),
    .dout_valid_o  (dout_valid),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: item j of a stream is pattern bit (MSB first) or a gap zero,
  // repeating with period PAT_W+gap.
  function automatic bit exp_bit(input logic [3:0] pat, input int gap, input int j);
    int pos;
    logic [3:0] p;
    p   = pat;
    pos = j % (4 + gap);
    return (pos < 4) ? p[3-pos] : 1'b0;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy !== dout_valid) begin
        errors++;
        $display("FAIL busy_vs_valid cyc=%0d busy=%b valid=%b", cyc, busy, dout_valid);
      end
      if (dout_valid !== 1'b1) begin
        checks++;
        if (dout !== 1'b0) begin
          errors++;
          $display("FAIL idle_dout cyc=%0d dout=%b exp=0", cyc, dout);
        end
      end
      if (dout_valid === 1'b1 || done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d done/valid/dout=%b%b%b exp=none",
                   cyc, done, dout_valid, dout);
        end else begin
          item_t it;
          logic [2:0] got, want;
          it   = exp_q.pop_front();
          got  = {done, dout_valid, dout};
          want = {it.is_done, !it.is_done, it.b};
          if (got !== want || cyc != it.cyc) begin
            errors++;
            $display("FAIL stream_item got done/valid/dout=%b at cyc %0d exp=%b at cyc %0d",
                     got, cyc, want, it.cyc);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    checks++;
    if ({dout, dout_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL %s dout/valid/busy/done=%b%b%b%b exp=0000",
               name, dout, dout_valid, busy, done);
    end
  endtask

  task automatic maybe_poke(input bit poke);
    if (poke && $urandom_range(0, 2) == 0) begin
      start       = 1'b1;
      use_default = 1'($urandom_range(0, 1));
      pattern_in  = 4'($urandom_range(0, 15));
      rep_count   = 8'($urandom_range(0, 9));
      gap_len     = 4'($urandom_range(0, 15));
    end
  endtask

  // Launch one transfer at the current negedge.
  // mode: 0 run to completion, 1 abort, 2 reset, applied while item stop_at
  // (1-based) is on the line. Returns at a negedge with the DUT idle; for
  // mode 0 with rep!=0 that negedge is the done cycle.
  task automatic launch(input bit ud, input logic [3:0] pin, input int rep,
                        input int gap, input int mode_in, input int stop_at,
                        input bit poke);
    logic [3:0] pat;
    int  c, len, n, mode;
    bit  endless;
    item_t it;
    pat     = ud ? DEF_PAT : pin;
    mode    = mode_in;
    endless = 1'b0;
`ifdef PATTERN_TX_CONTINUOUS_EN
    endless = (rep == 0);
`endif
    len = (rep == 0) ? 0 : rep * 4 + (rep - 1) * gap;
    if (endless) len = stop_at;
    if (mode != 0 && stop_at >= 1 && stop_at <= len) n = stop_at;
    else begin
      mode = 0;
      n    = len;
    end
    c = cyc;
    for (int j = 0; j < n; j++) begin
      it.is_done = 1'b0;
      it.b       = exp_bit(pat, gap, j);
      it.cyc     = c + 1 + j;
      exp_q.push_back(it);
    end
    if (mode == 0 && rep != 0) begin
      it.is_done = 1'b1;
      it.b       = 1'b0;
      it.cyc     = c + 1 + len;
      exp_q.push_back(it);
    end
    start       = 1'b1;
    use_default = ud;
    pattern_in  = pin;
    rep_count   = 8'(rep);
    gap_len     = 4'(gap);
    @(negedge clk);
    start       = 1'b0;
    use_default = 1'($urandom_range(0, 1));
    pattern_in  = 4'($urandom_range(0, 15));
    rep_count   = 8'($urandom_range(0, 255));
    gap_len     = 4'($urandom_range(0, 15));
    if (mode == 0) begin
      if (len == 0) begin
        repeat (4) @(negedge clk);
      end else begin
        while (cyc < c + 1 + len) begin
          maybe_poke(poke);
          @(negedge clk);
          start = 1'b0;
        end
      end
    end else begin
      while (cyc < c + stop_at) begin
        maybe_poke(poke);
        @(negedge clk);
        start = 1'b0;
      end
      maybe_poke(poke);
      if (mode == 1) abort = 1'b1;
      else           reset = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      reset = 1'b0;
      start = 1'b0;
      check_all_zero(mode == 1 ? "after_abort" : "after_reset");
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    use_default = 1'b0;
    pattern_in  = 4'h0;
    rep_count   = 8'h0;
    gap_len     = 4'h0;
    abort       = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed
    launch(1'b1, 4'h0, 1, 0, 0, 0, 1'b0);          // default 1001 once
    repeat (2) @(negedge clk);
    launch(1'b0, 4'b1101, 3, 2, 0, 0, 1'b1);       // 1101 00 1101 00 1101
    repeat (2) @(negedge clk);
    launch(1'b1, 4'h0, 2, 0, 0, 0, 1'b0);          // 10011001 no bubble
    repeat (2) @(negedge clk);
    launch(1'b0, 4'b1011, 2, 3, 1, 3, 1'b1);       // abort on 3rd bit
    repeat (3) @(negedge clk);
    launch(1'b1, 4'h0, 0, 1, 1, 40, 1'b0);         // rep 0: ignored or endless
    repeat (3) @(negedge clk);
    launch(1'b0, 4'b0110, 4, 2, 2, 5, 1'b0);       // reset in first gap cycle
    @(negedge clk);
    launch(1'b0, 4'b1110, 1, 0, 0, 0, 1'b0);
    launch(1'b0, 4'b0111, 1, 0, 0, 0, 1'b0);       // start in done cycle
    launch(1'b1, 4'h0, 1, 0, 0, 0, 1'b0);          // and again, chained
    repeat (2) @(negedge clk);

    // Randomized
    for (int t = 0; t < 60; t++) begin
      bit ud;
      logic [3:0] pin;
      int rep, gap, mode, stop_at, len;
      bit endless;
      ud      = 1'($urandom_range(0, 1));
      pin     = 4'($urandom_range(0, 15));
      rep     = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      gap     = $urandom_range(0, 3);
      mode    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      endless = 1'b0;
`ifdef PATTERN_TX_CONTINUOUS_EN
      endless = (rep == 0);
`endif
      len = (rep == 0) ? 0 : rep * 4 + (rep - 1) * gap;
      if (endless) begin
        if (mode == 0) mode = 1;
        stop_at = $urandom_range(1, 30);
      end else begin
        stop_at = (len > 0) ? $urandom_range(1, len) : 0;
      end
      launch(ud, pin, rep, gap, mode, stop_at, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d items still pending exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_serial_tx.md
Name: pattern_serial_tx

Overview:
Serial pattern transmitter; the transmit-side counterpart to the team's Mealy sequence detectors.
- Serializes a programmable PAT_W-bit pattern (default 1001) MSB-first onto a 1-bit line.
- Supports a repetition count and a zero-filled inter-pattern gap.
- Used to drive detector inputs and as a framing-marker generator on serial links.
- All outputs are registered.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
DEF_PATTERN, 4'b1001, pattern latched when use_default=1
CNT_W, 8, repetition counter width
GAP_W, 4, gap-length field width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only while idle (busy=0)
use_default  input  1  at start: 1 selects DEF_PATTERN, 0 selects pattern_in
pattern_in  input  PAT_W  pattern, latched on accepted start
rep_count  input  CNT_W  number of pattern repetitions, latched on accepted start
gap_len  input  GAP_W  zero bits between repetitions, latched on accepted start
abort  input  1  terminate current transfer
dout  output  1  serial data
dout_valid  output  1  dout carries a transmitted bit (pattern or gap)
busy  output  1  transfer in progress
done  output  1  one-cycle pulse after the final bit of a completed transfer

Behaviour:
- Reset: synchronous, active-high. Next edge forces state IDLE; dout=0, dout_valid=0, busy=0, done=0; all counters and latches cleared. Applies mid-transfer with no done pulse.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - dout=0, dout_valid=0, busy=0.
  - Start accepted when start=1 and rep_count!=0: latch pattern, rep_count, gap_len; go to SHIFT with bit index = PAT_W-1.
  - start with rep_count==0 is ignored; no output activity, no done.
- SHIFT:
  - Latency: first bit (pattern MSB) appears on dout with dout_valid=1 and busy=1 in the cycle after start is sampled.
  - One bit per cycle, MSB-first, PAT_W cycles per repetition.
- After the last bit of a repetition:
  - Repetitions remaining and gap_len>0: GAP for exactly gap_len cycles, dout=0, dout_valid=1; then SHIFT.
  - Repetitions remaining and gap_len==0: back-to-back; next pattern MSB follows the LSB with no bubble.
  - Last repetition: go to IDLE. done=1 for one cycle in that IDLE cycle, with busy=0 and dout_valid=0.
- Transfer length: rep_count*PAT_W + (rep_count-1)*gap_len valid cycles. No trailing gap.
- start while busy=1 is ignored; latched fields are not disturbed.
- start in the done cycle is accepted, because state is IDLE. Next transfer starts one cycle later.
- Abort:
  - abort=1 while busy: next cycle IDLE, dout=0, dout_valid=0, busy=0, no done pulse.
  - abort has priority over start in the same cycle.
  - abort while idle has no effect.
- Counters:
  - Bit index: down-counts PAT_W-1..0.
  - Gap counter: loads gap_len, decrements to 1.
  - Rep counter: decrements on each completed pattern.
  - No wrap-around is reachable: every counter reloads before underflow.

Optional Feature:
- Macro PATTERN_TX_CONTINUOUS_EN.
- Defined: start with rep_count==0 begins endless repetition (pattern, gap, pattern, ...) until abort or reset. done never asserts in this mode. rep_count!=0 behaves as the base block.
- Undefined: rep_count==0 start is ignored, as in the base behaviour.

Decomposition:
- Package pattern_tx_pkg holds:
  - state encoding typedef (IDLE, SHIFT, GAP);
  - DEF_PATTERN default constant;
  - width defaults for CNT_W and GAP_W.
- One sub-module, tx_down_counter: parameterized width; load/decrement; zero flag. Instantiated three times (bit index, gap, repetition).

Test Plan:
1. reset, then start, use_default=1, rep=1, gap=0 -> cycles +1..+4: dout=1,0,0,1, valid=1, busy=1; cycle +5: done=1, busy=0, valid=0.
2. start, pattern_in=4'b1101, use_default=0, rep=3, gap=2 -> 16 valid cycles 1101 00 1101 00 1101; exactly one done; busy deasserts with done.
3. start, default pattern, rep=2, gap=0, feeding the 1001 non-overlapping detector -> stream 10011001 with no bubble; detector pulses twice.
4. rep=2, gap=3; abort on 3rd bit of rep 1; start re-pulsed while busy -> next cycle valid=0, busy=0; no done; ignored start changes nothing.
5. start with rep=0 -> no valid, no done. With PATTERN_TX_CONTINUOUS_EN -> 1001 0 1001 0 ... (gap=1) for 40 cycles until abort; done stays 0.
6. reset asserted mid-GAP of a rep=4 transfer, then start in the done cycle of a fresh rep=1 transfer -> reset: all outputs 0 next cycle. Fresh transfer: second transfer's MSB on dout one cycle after done.
